// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between two
//               requesters. Registers the winning op, drives the ALU, waits
//               a per-opcode cycle count (MUL/DIV are multicycle paths),
//               captures the result and returns it tagged with the id.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH         = 32,
    parameter int CTRL_W        = 5,
    parameter int MULDIV_CYCLES = 4    // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_err,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [WIDTH-1:0]  alu_srcA,
    output logic [WIDTH-1:0]  alu_srcB,
    input  logic [WIDTH-1:0]  alu_result,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Countdown preload for MUL/DIV; a value of 0 means one EXEC cycle.
    localparam logic [3:0]        C_MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);
    localparam logic [CTRL_W-1:0] C_OP_MUL      = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] C_OP_DIV      = CTRL_W'(5);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_last_grant;

    logic              w_idle;
    logic              w_grant;
    logic              w_accept;
    logic              w_illegal;
    logic              w_muldiv;
    logic [CTRL_W-1:0] w_ctrl;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;

    // Round-robin grant and ready: the port that did not win last time wins a tie.
    always_comb begin
        w_idle = (r_state == S_IDLE);
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end
        req0_ready = w_idle && req0_valid && !w_grant;
        req1_ready = w_idle && req1_valid &&  w_grant;
        w_accept   = req0_ready || req1_ready;
        w_ctrl     = w_grant ? req1_ctrl : req0_ctrl;
        w_a        = w_grant ? req1_a    : req0_a;
        w_b        = w_grant ? req1_b    : req0_b;
        w_muldiv   = (w_ctrl == C_OP_MUL) || (w_ctrl == C_OP_DIV);
    end

    // Opcode legality decode of the granted request.
    always_comb begin
        w_illegal = 1'b1;
        case (w_ctrl)
            CTRL_W'(1), CTRL_W'(2), CTRL_W'(3), CTRL_W'(4), CTRL_W'(5),
            CTRL_W'(6), CTRL_W'(9), CTRL_W'(10), CTRL_W'(11), CTRL_W'(12):
                w_illegal = 1'b0;
            default:
                w_illegal = 1'b1;
        endcase
    end

    // Control FSM: accept in IDLE, count down in EXEC, hold the response in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            alu_ctrl     <= '0;
            alu_srcA     <= '0;
            alu_srcB     <= '0;
            rsp_result   <= '0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_id       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_ctrl     <= w_ctrl;
                        alu_srcA     <= w_a;
                        alu_srcB     <= w_b;
                        rsp_id       <= w_grant;
                        r_last_grant <= w_grant;
                        rsp_err      <= w_illegal;
                        r_cnt        <= w_muldiv ? C_MULDIV_LOAD : 4'd0;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_valid  <= 1'b1;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters (e.g. scalar pipe and load/compress unit) under round-robin arbitration. It registers the winning request's opcode and operands, drives the ALU, waits a per-opcode cycle count (MUL/DIV run as multicycle paths) and captures the result. It then returns the result on one response channel tagged with the requester id.

Parameters:
WIDTH, 32, operand/result width
CTRL_W, 5, ALU opcode width
MULDIV_CYCLES, 4, EXEC cycles for MUL (3) and DIV (5); legal range 1..15

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_ctrl  in  CTRL_W  requester 0 opcode
req0_a  in  WIDTH  requester 0 srcA
req0_b  in  WIDTH  requester 0 srcB
req1_valid, req1_ready, req1_ctrl, req1_a, req1_b  same as requester 0, for requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that issued the op
rsp_result  out  WIDTH  captured ALU result
rsp_err  out  1  opcode was not a legal ALU op
alu_ctrl  out  CTRL_W  to ALU opcode input
alu_srcA  out  WIDTH  to ALU srcA
alu_srcB  out  WIDTH  to ALU srcB
alu_result  in  WIDTH  from ALU result
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; alu_ctrl, alu_srcA, alu_srcB, rsp_result = 0; rsp_valid, rsp_err, rsp_id, busy = 0; cnt=0; last_grant=1, so port 0 wins first.
- Legal opcodes: 1 ADD, 2 SUB, 3 MUL, 4 MOVE, 5 DIV, 6 LNUM, 9 AND, 10 OR, 11 XOR, 12 NOT. All others are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the only valid port. If both ports are valid, grant = the port != last_grant.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational from valid. ready is never high in EXEC or RESP.
  - On valid&ready: latch ctrl/a/b into alu_ctrl/alu_srcA/alu_srcB, rsp_id=N, last_grant=N, rsp_err = illegal(ctrl).
  - Set cnt = (ctrl==3 || ctrl==5) ? MULDIV_CYCLES-1 : 0, then go to EXEC.
- EXEC:
  - ALU inputs are held stable.
  - If cnt!=0, decrement cnt.
  - If cnt==0, capture rsp_result = alu_result, set rsp_valid=1 and go to RESP.
  - Illegal ops take 1 cycle; whatever the ALU returns is captured and flagged with rsp_err=1.
- RESP:
  - rsp_valid, rsp_id, rsp_result and rsp_err are held stable while rsp_ready=0.
  - On rsp_ready=1: clear rsp_valid and rsp_err next edge, then go to IDLE. New requests are accepted only from IDLE, one cycle later.
- Latency, handshake edge T to rsp_valid high: T+1 for single-cycle ops, T+MULDIV_CYCLES for MUL/DIV. Minimum issue interval = latency + 2 cycles.
- alu_* outputs keep the last op's values in IDLE, so no toggling without a request.
- Requester rules:
  - A requester holding valid while not granted keeps its payload stable. The arbiter never drops it.
  - A request deasserted before grant is simply not served.
- Starvation: with both ports valid continuously, grants alternate 0,1,0,1.
- Reset asserted in EXEC or RESP aborts the op. No response is ever produced for it, and the round-robin pointer returns to its reset value.

Test Plan:
- Port0 ADD a=1 b=5, port1 idle -> req0_ready high in IDLE. One cycle later rsp_valid=1, rsp_id=0, rsp_result=6, rsp_err=0.
- Same edge: port0 SUB 2,1 and port1 MUL 2,8 (MULDIV_CYCLES=4) -> port0 served first with result 1. Port1 is then accepted and rsp_valid rises exactly 4 cycles after its handshake with result 16, id 1. Port1 payload is held throughout.
- Port0 LNUM a=134941186 b=3 with rsp_ready low for 5 cycles -> rsp_result=10 held stable, busy=1, both readys low. Release takes it, and IDLE returns the next cycle.
- Both ports continuously valid with AND 1,1 and OR 0,1, rsp_ready=1 -> grants alternate 0,1,0,1 with results 1,1 alternating ids.
- Port1 ctrl=7 -> single-cycle EXEC, rsp_err=1, rsp_id=1. The next legal op (XOR 0,1 -> 1) has rsp_err=0.
- DIV 16/4 accepted, rst_n pulsed low mid-EXEC -> all outputs return to 0 immediately with no response. A post-reset simultaneous request from both ports grants port 0; NOT 0 returns 32'hFFFFFFFF.
